// File: rtl/param_data_path.sv
// Parameterized processor datapath: instruction register and decode, 4-entry
// register file, ALU with registered flags, program counter and address mux.
package param_data_path_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNEG   = 4'd10,
        I_BOV    = 4'd11,
        I_BNOV   = 4'd12,
        I_BNNEG  = 4'd13,
        I_BNZERO = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module param_data_path
    import param_data_path_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    input  logic [DATA_W-1:0]       data_in,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out
);
    localparam int NREGS = 4;
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [15:0]             ir_r;
    logic [ADDR_W-1:0]       pc_r;
    logic [DATA_W-1:0]       regs_r [NREGS];
    logic                    zero_r;
    logic                    neg_r;
    logic                    uov_r;
    logic                    sov_r;

    decoded_instruction_type dec_s;
    logic [1:0]              sel_a_s;
    logic [1:0]              sel_b_s;
    logic [1:0]              sel_c_s;
    logic [ADDR_W-1:0]       mem_addr_s;
    logic [DATA_W-1:0]       bus_a_s;
    logic [DATA_W-1:0]       bus_b_s;
    logic [DATA_W-1:0]       bus_c_s;
    logic [DATA_W:0]         sum_s;
    logic [DATA_W-1:0]       diff_s;
    logic [DATA_W-1:0]       alu_out_s;
    logic                    alu_zero_s;
    logic                    alu_neg_s;
    logic                    alu_uov_s;
    logic                    alu_sov_s;
    logic                    unused_ir_s;

    // Bit 7 of the instruction is not part of any field.
    assign unused_ir_s = ir_r[7];

    // Opcode decode from the upper instruction byte.
    always_comb begin
        dec_s = I_NOP;
        case (ir_r[15:8])
            8'h81:   dec_s = I_LOAD;
            8'h82:   dec_s = I_STORE;
            8'h91:   dec_s = I_MOVE;
            8'hA1:   dec_s = I_ADD;
            8'hA2:   dec_s = I_SUB;
            8'hA3:   dec_s = I_AND;
            8'hA4:   dec_s = I_OR;
            8'h01:   dec_s = I_BRANCH;
            8'h02:   dec_s = I_BZERO;
            8'h03:   dec_s = I_BNEG;
            8'h05:   dec_s = I_BOV;
            8'h06:   dec_s = I_BNOV;
            8'h0A:   dec_s = I_BNNEG;
            8'h0B:   dec_s = I_BNZERO;
            8'hFF:   dec_s = I_HALT;
            default: dec_s = I_NOP;
        endcase
    end

    // Register selectors and memory address field; unused fields stay 0.
    always_comb begin
        sel_a_s    = 2'd0;
        sel_b_s    = 2'd0;
        sel_c_s    = 2'd0;
        mem_addr_s = ADDR_ZERO;
        case (dec_s)
            I_LOAD: begin
                sel_c_s    = ir_r[6:5];
                mem_addr_s = ir_r[ADDR_W-1:0];
            end
            I_STORE: begin
                sel_a_s    = ir_r[6:5];
                mem_addr_s = ir_r[ADDR_W-1:0];
            end
            I_MOVE: begin
                sel_c_s = ir_r[3:2];
                sel_a_s = ir_r[1:0];
                sel_b_s = ir_r[1:0];
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
                sel_a_s = ir_r[1:0];
                sel_b_s = ir_r[3:2];
                sel_c_s = ir_r[5:4];
            end
            I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO: begin
                mem_addr_s = ir_r[ADDR_W-1:0];
            end
            default: mem_addr_s = ADDR_ZERO;
        endcase
    end

    assign bus_a_s = regs_r[sel_a_s];
    assign bus_b_s = regs_r[sel_b_s];
    assign bus_c_s = c_sel ? alu_out_s : data_in;

    // ALU result and the four flag terms.
    always_comb begin
        sum_s     = {1'b0, bus_a_s} + {1'b0, bus_b_s};
        diff_s    = bus_a_s - bus_b_s;
        alu_out_s = DATA_ZERO;
        alu_uov_s = 1'b0;
        alu_sov_s = 1'b0;
        case (operation)
            2'b00: begin
                alu_out_s = sum_s[DATA_W-1:0];
                alu_uov_s = sum_s[DATA_W];
                alu_sov_s = (bus_a_s[DATA_W-1] == bus_b_s[DATA_W-1]) &&
                            (sum_s[DATA_W-1] != bus_a_s[DATA_W-1]);
            end
            2'b01: begin
                alu_out_s = diff_s;
                alu_uov_s = (bus_a_s < bus_b_s);
                alu_sov_s = (bus_a_s[DATA_W-1] != bus_b_s[DATA_W-1]) &&
                            (diff_s[DATA_W-1] != bus_a_s[DATA_W-1]);
            end
            2'b10:   alu_out_s = bus_a_s & bus_b_s;
            2'b11:   alu_out_s = bus_a_s | bus_b_s;
            default: alu_out_s = DATA_ZERO;
        endcase
        alu_zero_s = (alu_out_s == DATA_ZERO);
        alu_neg_s  = alu_out_s[DATA_W-1];
    end

    // Instruction register: only the low 16 bits of the bus carry instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 16'h0000;
        end else if (ir_enable) begin
            ir_r <= data_in[15:0];
        end
    end

    // Program counter: branch target load or wrapping increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= ADDR_ZERO;
        end else if (pc_enable) begin
            pc_r <= branch ? mem_addr_s : (pc_r + ADDR_W'(1'b1));
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= DATA_ZERO;
            end
        end else if (write_reg_enable) begin
            regs_r[sel_c_s] <= bus_c_s;
        end
    end

    // Flags register, loaded from the same ALU result as the register write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            uov_r  <= 1'b0;
            sov_r  <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_r <= alu_zero_s;
            neg_r  <= alu_neg_s;
            uov_r  <= alu_uov_s;
            sov_r  <= alu_sov_s;
        end
    end

    assign decoded_instruction = dec_s;
    assign zero_op             = zero_r;
    assign neg_op              = neg_r;
    assign unsigned_overflow   = uov_r;
    assign signed_overflow     = sov_r;
    assign ram_addr            = addr_sel ? mem_addr_s : pc_r;
    assign data_out            = bus_a_s;

endmodule

// File: tb/tb_param_data_path.sv
// Bench for param_data_path: 16-bit and 32-bit instances sharing stimulus,
// compared against an arithmetic reference model of the instruction set.
`timescale 1ns/1ps
module tb_param_data_path;
    import param_data_path_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        branch, pc_enable, ir_enable, addr_sel, c_sel, wre, fre;
    logic [1:0]  operation;
    logic [31:0] data_in;

    decoded_instruction_type dec16, dec32;
    logic        z16, n16, uo16, so16, z32, n32, uo32, so32;
    logic [4:0]  ram16, ram32;
    logic [15:0] dout16;
    logic [31:0] dout32;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0]       m_ir;
    int                m_pc;
    longint unsigned   m_reg [2][4];
    logic              m_z [2], m_n [2], m_uo [2], m_so [2];

    logic [7:0] opcodes [16] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01,
                                 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF, 8'h55};

    param_data_path #(.DATA_W(16), .ADDR_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .write_reg_enable(wre), .flags_reg_enable(fre), .operation(operation),
        .data_in(data_in[15:0]), .decoded_instruction(dec16), .zero_op(z16),
        .neg_op(n16), .unsigned_overflow(uo16), .signed_overflow(so16),
        .ram_addr(ram16), .data_out(dout16));

    param_data_path #(.DATA_W(32), .ADDR_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .write_reg_enable(wre), .flags_reg_enable(fre), .operation(operation),
        .data_in(data_in), .decoded_instruction(dec32), .zero_op(z32),
        .neg_op(n32), .unsigned_overflow(uo32), .signed_overflow(so32),
        .ram_addr(ram32), .data_out(dout32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic decoded_instruction_type ref_decode(input logic [15:0] ir);
        case (ir[15:8])
            8'h81: return I_LOAD;   8'h82: return I_STORE;  8'h91: return I_MOVE;
            8'hA1: return I_ADD;    8'hA2: return I_SUB;    8'hA3: return I_AND;
            8'hA4: return I_OR;     8'h01: return I_BRANCH; 8'h02: return I_BZERO;
            8'h03: return I_BNEG;   8'h05: return I_BOV;    8'h06: return I_BNOV;
            8'h0A: return I_BNNEG;  8'h0B: return I_BNZERO; 8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    function automatic void ref_fields(input logic [15:0] ir, output int a, output int b,
                                       output int c, output int madr);
        decoded_instruction_type d;
        d = ref_decode(ir);
        a = 0; b = 0; c = 0; madr = 0;
        if (d == I_LOAD) begin
            c = int'(ir[6:5]); madr = int'(ir[4:0]);
        end else if (d == I_STORE) begin
            a = int'(ir[6:5]); madr = int'(ir[4:0]);
        end else if (d == I_MOVE) begin
            c = int'(ir[3:2]); a = int'(ir[1:0]); b = a;
        end else if (d inside {I_ADD, I_SUB, I_AND, I_OR}) begin
            a = int'(ir[1:0]); b = int'(ir[3:2]); c = int'(ir[5:4]);
        end else if (d inside {I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO}) begin
            madr = int'(ir[4:0]);
        end
    endfunction

    function automatic longint unsigned ref_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // ALU semantics as integer arithmetic: overflow means "true result out of range"
    function automatic void ref_alu(input int w, input longint unsigned a, input longint unsigned b,
                                    input logic [1:0] op, output longint unsigned r,
                                    output logic z, output logic n, output logic uo, output logic so);
        longint unsigned m;
        longint half, sa, sb, sr;
        m    = 64'd1 << w;
        half = longint'(m >> 1);
        sa   = (a >= (m >> 1)) ? longint'(a) - longint'(m) : longint'(a);
        sb   = (b >= (m >> 1)) ? longint'(b) - longint'(m) : longint'(b);
        uo = 1'b0; so = 1'b0; r = 64'd0;
        case (op)
            2'b00: begin
                r = (a + b) % m; uo = ((a + b) >= m);
                sr = sa + sb; so = (sr < -half) || (sr >= half);
            end
            2'b01: begin
                r = (a + m - b) % m; uo = (a < b);
                sr = sa - sb; so = (sr < -half) || (sr >= half);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        z = (r == 64'd0);
        n = (r >= (m >> 1));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ir = 16'h0000;
        m_pc = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) m_reg[k][j] = 64'd0;
            m_z[k] = 1'b0; m_n[k] = 1'b0; m_uo[k] = 1'b0; m_so[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int a, b, c, madr, w;
        longint unsigned r, busc;
        logic z, n, uo, so;
        ref_fields(m_ir, a, b, c, madr);
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 16 : 32;
            ref_alu(w, m_reg[k][a], m_reg[k][b], operation, r, z, n, uo, so);
            busc = c_sel ? r : (64'(data_in) & ref_mask(w));
            if (fre) begin
                m_z[k] = z; m_n[k] = n; m_uo[k] = uo; m_so[k] = so;
            end
            if (wre) m_reg[k][c] = busc;
        end
        if (pc_enable) m_pc = branch ? madr : (m_pc + 1) % 32;
        if (ir_enable) m_ir = data_in[15:0];
    endtask

    task automatic check_all();
        int a, b, c, madr;
        logic [63:0] exp_ra;
        ref_fields(m_ir, a, b, c, madr);
        exp_ra = addr_sel ? 64'(madr) : 64'(m_pc);
        check("dec16", 64'(dec16), 64'(ref_decode(m_ir)));
        check("dec32", 64'(dec32), 64'(ref_decode(m_ir)));
        check("ram16", 64'(ram16), exp_ra);
        check("ram32", 64'(ram32), exp_ra);
        check("dout16", 64'(dout16), m_reg[0][a]);
        check("dout32", 64'(dout32), m_reg[1][a]);
        check("flags16", {60'd0, z16, n16, uo16, so16}, {60'd0, m_z[0], m_n[0], m_uo[0], m_so[0]});
        check("flags32", {60'd0, z32, n32, uo32, so32}, {60'd0, m_z[1], m_n[1], m_uo[1], m_so[1]});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0;
        c_sel = 1'b0; wre = 1'b0; fre = 1'b0; operation = 2'b00; data_in = 32'h0;
    endtask

    task automatic set_ir(input logic [15:0] v);
        data_in = {16'h0000, v}; ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        set_ir(16'h8100 | (16'(idx) << 5));
        data_in = v; c_sel = 1'b0; wre = 1'b1;
        tick();
        wre = 1'b0;
    endtask

    // Reset asserted between edges with all enables active, then released.
    task automatic mid_reset();
        pc_enable = 1'b1; ir_enable = 1'b1; wre = 1'b1; fre = 1'b1; c_sel = 1'b1;
        data_in = 32'hA5A5_8161;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_async_dec", 64'(dec16), 64'(I_NOP));
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        check("reset_ram", 64'(ram16), 64'd0);
        rst_n = 1'b1;

        // PC walks 0..31 and wraps to 0
        pc_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("pc_walk", 64'(ram16), 64'((i + 1) % 32));
        end
        pc_enable = 1'b0;

        // LOAD into R2, then STORE R2 to address 2
        set_ir(16'h8141);
        data_in = 32'h0000_1234; c_sel = 1'b0; wre = 1'b1;
        tick();
        wre = 1'b0;
        set_ir(16'h8242);
        addr_sel = 1'b1;
        #1;
        check("store_addr", 64'(ram16), 64'd2);
        check("store_data", 64'(dout16), 64'h1234);
        addr_sel = 1'b0;

        // 0x7FFF + 1 sets negative and signed overflow
        load_reg(0, 32'h0000_7FFF);
        load_reg(1, 32'h0000_0001);
        set_ir(16'hA104);
        operation = 2'b00; c_sel = 1'b1; wre = 1'b1; fre = 1'b1;
        tick();
        wre = 1'b0; fre = 1'b0;
        check("add_r0", 64'(dout16), 64'h8000);
        check("add_flags", {60'd0, z16, n16, uo16, so16}, 64'b0101);
        check("add_flags32", {60'd0, z32, n32, uo32, so32}, 64'b0000);

        // 0 - 1 borrows; equal operands give zero
        load_reg(0, 32'h0000_0000);
        load_reg(1, 32'h0000_0001);
        set_ir(16'hA204);
        operation = 2'b01; c_sel = 1'b1; wre = 1'b1; fre = 1'b1;
        tick();
        wre = 1'b0; fre = 1'b0;
        check("sub_r0", 64'(dout16), 64'hFFFF);
        check("sub_flags", {60'd0, z16, n16, uo16, so16}, 64'b0110);
        check("sub_r0_32", 64'(dout32), 64'hFFFF_FFFF);
        load_reg(0, 32'h0000_5A5A);
        load_reg(1, 32'h0000_5A5A);
        set_ir(16'hA204);
        operation = 2'b01; fre = 1'b1;
        tick();
        fre = 1'b0;
        check("sub_zero", {60'd0, z16, n16, uo16, so16}, 64'b1000);

        // Branch loads PC; unknown opcode decodes as NOP; reset mid-cycle
        set_ir(16'h0113);
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        branch = 1'b0; pc_enable = 1'b0;
        check("branch_pc", 64'(ram16), 64'h13);
        set_ir(16'h5500);
        check("nop_decode", 64'(dec16), 64'(I_NOP));
        mid_reset();
        check("rst_ram", 64'(ram16), 64'd0);

        // Wide instance: all-ones + 1
        load_reg(0, 32'hFFFF_FFFF);
        load_reg(1, 32'h0000_0001);
        set_ir(16'hA104);
        operation = 2'b00; fre = 1'b1;
        tick();
        fre = 1'b0;
        check("wide_add_flags", {60'd0, z32, n32, uo32, so32}, 64'b1010);

        // Randomized traffic with valid and invalid opcodes
        for (int i = 0; i < 300; i++) begin
            branch    = 1'($urandom_range(0, 1));
            pc_enable = 1'($urandom_range(0, 1));
            ir_enable = ($urandom_range(0, 2) == 0);
            addr_sel  = 1'($urandom_range(0, 1));
            c_sel     = 1'($urandom_range(0, 1));
            wre       = 1'($urandom_range(0, 1));
            fre       = 1'($urandom_range(0, 1));
            operation = 2'($urandom_range(0, 3));
            data_in   = $urandom;
            if (ir_enable) data_in[15:8] = opcodes[$urandom_range(0, 15)];
            tick();
        end
        mid_reset();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
